// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and memory-write bundle for the instruction
// memory loader.
//   rx_data  [7:0]        incoming byte from the host link
//   rx_valid              rx_data is valid
//   rx_ready              loader accepts a byte this cycle
//   we                    memory write enable, one pulse per word
//   waddr    [ADDR_W-1:0] memory word address
//   wdata    [DATA_W-1:0] memory write data
// Modports: slave  = loader side (consumes bytes, drives the memory write)
//           master = host side (drives bytes, observes the memory write)
interface imem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport slave  (input rx_data, rx_valid, output rx_ready, we, waddr, wdata);
  modport master (output rx_data, rx_valid, input rx_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a byte stream (2-byte little-endian word count N, then N 32-bit
// little-endian words), packs the bytes into words and writes them to
// consecutive addresses from 0. The core is held in reset while loading.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: after the last word, one
// trailer byte is accepted that must equal the XOR of all payload bytes.
// Ports:
//   CLK        system clock, rising edge
//   RST_n      asynchronous active-low reset
//   start      single-cycle pulse, begins a load session when not busy
//   bus        imem_loader_if.slave (rx byte handshake + memory write)
//   cpu_rst_n  active-low reset to the core
//   busy       session in progress
//   done       last session completed successfully (sticky)
//   err        last session aborted (sticky)
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_BYTE,
    S_WRITE,
    S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_ERR
  } state_t;

  state_t            state, nxt;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [1:0]        bcnt;
  logic [23:0]       asm_p0;
  logic [15:0]       n_full;
  logic              xfer;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer      = bus.rx_valid && bus.rx_ready;
  assign n_full    = {bus.rx_data, n_q[7:0]};
  assign idx_inc   = idx + 1'b1;
  // Index is one bit wider than the address so N = 2**ADDR_W terminates
  // cleanly instead of wrapping.
  assign last_word = 32'(idx_inc) == 32'(n_q);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_HDR_LO;
      S_HDR_LO: if (xfer) nxt = S_HDR_HI;
      S_HDR_HI: begin
        if (xfer) begin
          if (n_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            nxt = S_CHK;
`else
            nxt = S_DONE;
`endif
          else if (32'(n_full) > (32'd1 << ADDR_W))
            nxt = S_ERR;
          else
            nxt = S_BYTE;
        end
      end
      S_BYTE: if (xfer && bcnt == 2'd3) nxt = S_WRITE;
      S_WRITE: begin
        if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          nxt = S_CHK;
`else
          nxt = S_DONE;
`endif
        else
          nxt = S_BYTE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= S_IDLE;
      bus.rx_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      n_q          <= '0;
      idx          <= '0;
      bcnt         <= '0;
      asm_p0       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      // Status outputs are registered from the next-state decode so they
      // line up with the state they describe.
      state        <= nxt;
      bus.we       <= (nxt == S_WRITE);
      done         <= (nxt == S_DONE);
      err          <= (nxt == S_ERR);
      cpu_rst_n    <= (nxt == S_IDLE) || (nxt == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      bus.rx_ready <= nxt inside {S_HDR_LO, S_HDR_HI, S_BYTE, S_CHK};
      busy         <= nxt inside {S_HDR_LO, S_HDR_HI, S_BYTE, S_WRITE, S_CHK};
`else
      bus.rx_ready <= nxt inside {S_HDR_LO, S_HDR_HI, S_BYTE};
      busy         <= nxt inside {S_HDR_LO, S_HDR_HI, S_BYTE, S_WRITE};
`endif

      if ((state inside {S_IDLE, S_DONE, S_ERR}) && start) begin
        idx  <= '0;
        bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end

      if (xfer) begin
        unique case (state)
          S_HDR_LO: n_q[7:0] <= bus.rx_data;
          S_HDR_HI: begin
            n_q[15:8] <= bus.rx_data;
            idx       <= '0;
            bcnt      <= '0;
          end
          S_BYTE: begin
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.rx_data;
`endif
            // Bytes 0..2 shift in from the top; byte 3 completes the word,
            // which is published together with its address for WRITE.
            if (bcnt == 2'd3) begin
              bus.wdata <= DATA_W'({bus.rx_data, asm_p0});
              bus.waddr <= idx[ADDR_W-1:0];
            end else begin
              asm_p0 <= {bus.rx_data, asm_p0[23:8]};
            end
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) idx <= idx_inc;
    end
  end

endmodule
